// File: rtl/memory_cc_pkg.sv
// Shared widths and ResultSrc encoding for the pipeline stages.
package memory_cc_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    typedef enum logic {
        RES_ALU = 1'b0,
        RES_MEM = 1'b1
    } result_src_e;

endpackage

// File: rtl/memory_cc_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
module data_mem
    import memory_cc_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    // Contents start at zero and are never touched by reset.
    logic [XLEN-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_cc.sv
// Memory stage: data-memory access, MEM/WB register and writeback mux.
// Define MEM_PERF_CNT_EN to build the load/store retirement counters.
module memory_cc
    import memory_cc_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic             ResultSrcM,
    input  logic             MemWriteM,
    input  logic [REG_W-1:0] RDM,
    input  logic [XLEN-1:0]  WriteDataM,
    input  logic [XLEN-1:0]  ALUResultM,
    output logic             RegWriteW,
    output logic [REG_W-1:0] RDW,
    output logic [XLEN-1:0]  ResultW,
    output logic [XLEN-1:0]  LoadCnt,
    output logic [XLEN-1:0]  StoreCnt
);

    logic [XLEN-1:0] read_data;
    result_src_e     ResultSrcW;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;

    data_mem #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_data_mem (
        .clk  (clk),
        .we   (MemWriteM),
        .addr (ALUResultM[ADDR_W+1:2]),
        .wdata(WriteDataM),
        .rdata(read_data)
    );

    // read_data is sampled before the same-edge write lands, so a
    // concurrent load+store to one address returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= RES_ALU;
            RDW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= result_src_e'(ResultSrcM);
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= read_data;
        end
    end

    always_comb begin
        ResultW = (ResultSrcW == RES_MEM) ? ReadDataW : ALUResultW;
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            LoadCnt  <= '0;
            StoreCnt <= '0;
        end else begin
            if (ResultSrcM) LoadCnt  <= LoadCnt + 32'd1;
            if (MemWriteM)  StoreCnt <= StoreCnt + 32'd1;
        end
    end
`else
    assign LoadCnt  = '0;
    assign StoreCnt = '0;
`endif

endmodule

// File: tb/tb_memory_cc.sv
// Directed self-checking bench for memory_cc (default DEPTH=64).
module tb_memory_cc;
    import memory_cc_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             RegWriteM;
    logic             ResultSrcM;
    logic             MemWriteM;
    logic [REG_W-1:0] RDM;
    logic [XLEN-1:0]  WriteDataM;
    logic [XLEN-1:0]  ALUResultM;
    logic             RegWriteW;
    logic [REG_W-1:0] RDW;
    logic [XLEN-1:0]  ResultW;
    logic [XLEN-1:0]  LoadCnt;
    logic [XLEN-1:0]  StoreCnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    memory_cc #(
        .DEPTH (64),
        .ADDR_W(6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RegWriteM (RegWriteM),
        .ResultSrcM(ResultSrcM),
        .MemWriteM (MemWriteM),
        .RDM       (RDM),
        .WriteDataM(WriteDataM),
        .ALUResultM(ALUResultM),
        .RegWriteW (RegWriteW),
        .RDW       (RDW),
        .ResultW   (ResultW),
        .LoadCnt   (LoadCnt),
        .StoreCnt  (StoreCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic rs, input logic mw, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [31:0] addr);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        RDM        = rd;
        WriteDataM = wd;
        ALUResultM = addr;
    endtask

    task automatic check_w_zero(input string tag);
        check({tag, "_regwrite"}, {31'd0, RegWriteW}, 32'd0);
        check({tag, "_rd"},       {27'd0, RDW},       32'd0);
        check({tag, "_result"},   ResultW,            32'd0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'd0, addr);
        tick();
        check(tag, ResultW, exp);
    endtask

    logic [31:0] exp_loads;
    logic [31:0] exp_stores;

    initial begin
`ifdef MEM_PERF_CNT_EN
        exp_loads  = 32'd4;
        exp_stores = 32'd3;
`else
        exp_loads  = 32'd0;
        exp_stores = 32'd0;
`endif
        // Reset held for two edges with a live instruction in MEM
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 5'd5, 32'd0, 32'h1234);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_w_zero("reset");
            check("reset_loadcnt",  LoadCnt,  32'd0);
            check("reset_storecnt", StoreCnt, 32'd0);
        end
        rst = 1'b0;

        // ALU passthrough
        drive(1'b1, 1'b0, 1'b0, 5'd7, 32'd0, 32'd30);
        tick();
        check("alu_regwrite", {31'd0, RegWriteW}, 32'd1);
        check("alu_rd",       {27'd0, RDW},       32'd7);
        check("alu_result",   ResultW,            32'd30);

        // Store then load, low-bit and wrap aliasing, neighbouring word untouched
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF, 32'h10);
        tick();
        check("store_regwrite", {31'd0, RegWriteW}, 32'd0);
        load(32'h10, 32'hDEADBEEF, "load_0x10");
        check("load_rd", {27'd0, RDW}, 32'd3);
        load(32'h13,  32'hDEADBEEF, "load_0x13");
        load(32'h110, 32'hDEADBEEF, "load_0x110_wrap");
        load(32'h14,  32'h0,        "load_0x14_untouched");

        // Top word of the array
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'hA5A5_0001, 32'hFC);
        tick();
        load(32'hFC, 32'hA5A5_0001, "load_top_word");

        // Simultaneous store and load to the same word returns old data
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'd15, 32'h10);
        tick();
        drive(1'b1, 1'b1, 1'b1, 5'd3, 32'd20, 32'h10);
        tick();
        check("rw_same_old", ResultW, 32'd15);
        load(32'h10, 32'd20, "rw_same_new");

        // Counters: clear, then 3 loads, 2 stores, 1 load+store
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        rst = 1'b0;
        check("cnt_clear_load",  LoadCnt,  32'd0);
        check("cnt_clear_store", StoreCnt, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 5'd1, 32'd0, 32'h40);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd0, 32'(i + 100), 32'h40);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 5'd1, 32'd200, 32'h40);
        tick();
        check("cnt_both_old_data", ResultW, 32'd101);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        tick();
        check("cnt_loads",  LoadCnt,  exp_loads);
        check("cnt_stores", StoreCnt, exp_stores);
        rst = 1'b1;
        tick();
        check("cnt_rst_load",  LoadCnt,  32'd0);
        check("cnt_rst_store", StoreCnt, 32'd0);

        // Reset mid-stream: W drops the instruction, the store still lands
        rst = 1'b0;
        load(32'h10, 32'd20, "pre_midrst_load");
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd9, 32'h55, 32'h20);
        tick();
        check_w_zero("midrst");
        rst = 1'b0;
        load(32'h20, 32'h55, "midrst_store_kept");
        check("midrst_regwrite", {31'd0, RegWriteW}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/memory_cc.md
# memory_cc

Memory stage of the 5-stage RISC-V pipeline. Consumes the EX/MEM pipeline register outputs of the execute stage (RegWriteM, ResultSrcM, MemWriteM, RDM, WriteDataM, ALUResultM) and performs the data-memory access. It holds the MEM/WB pipeline register and drives ResultW, the writeback value that returns to the register file and to the execute stage's forwarding muxes.

## Interface
Parameters:
- DEPTH, 64, data-memory size in 32-bit words (power of two)
- ADDR_W, 6, word-index width, log2(DEPTH)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- RegWriteM  input  1  register-file write enable of the instruction in MEM
- ResultSrcM  input  1  1 = load (writeback from memory), 0 = ALU result
- MemWriteM  input  1  store enable
- RDM  input  5  destination register
- WriteDataM  input  32  store data
- ALUResultM  input  32  byte address, or ALU result
- RegWriteW  output  1  registered RegWriteM
- RDW  output  5  registered RDM
- ResultW  output  32  writeback value
- LoadCnt  output  32  count of loads retired through MEM
- StoreCnt  output  32  count of stores performed

## Operation
- Word index = ALUResultM[ADDR_W+1:2]. ALUResultM[1:0] is ignored (word access only). Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Store: when MemWriteM=1 on a rising edge, mem[index] <= WriteDataM. This applies in every cycle, including while rst=1.
- Load read is combinational from the array. The result is captured into ReadDataW at the same edge.
- The MEM/WB register captures RegWriteM, ResultSrcM, RDM, ALUResultM and the read data on every edge. There is no stall or enable input.
- ResultW = ResultSrcW ? ReadDataW : ALUResultW. This mux is combinational, after the register.
- Simultaneous MemWriteM=1 and ResultSrcM=1 at the same address: ReadDataW receives the pre-write (old) word. The new word is visible from the next access.
- Memory contents are not cleared by rst. At time zero the array is zero-initialised for simulation.

## Timing
- Latency is one cycle. Inputs sampled at edge N appear on RegWriteW, RDW and ResultW after edge N.
- The store becomes visible to a load sampled at edge N+1 or later.
- Reset values, applied at the first edge with rst=1:
  - RegWriteW=0, ResultSrcW=0, RDW=0, ALUResultW=0, ReadDataW=0, so ResultW=0.
  - LoadCnt=0, StoreCnt=0.
- Reset mid-stream: the instruction in MEM at the reset edge is dropped from W. A store presented at that edge still writes memory, because memory is not gated by reset.

## Configuration
- Macro: MEM_PERF_CNT_EN.
- Defined:
  - LoadCnt increments by 1 on each non-reset edge with ResultSrcM=1.
  - StoreCnt increments by 1 on each non-reset edge with MemWriteM=1.
  - Both counters wrap at 2^32 and are cleared by rst.
  - If both flags are high in the same cycle, both counters increment.
- Not defined: LoadCnt and StoreCnt are constant 0 and no counter registers are synthesised. Ports are present in both builds.

## Structure
- The shared package holds:
  - the word and register-index widths, XLEN=32 and REG_W=5;
  - the ResultSrc encoding constants, RES_ALU=0 and RES_MEM=1, shared with the decode stage and the execute stage.
- Sub-module data_mem: DEPTH x 32 array with synchronous write, asynchronous read and word index input.
- memory_cc instantiates data_mem and contains the MEM/WB register, the writeback mux and the optional counters.

## Test plan
1. Reset: hold rst=1 for 2 cycles while driving RegWriteM=1, RDM=5 and ALUResultM=0x1234. Required: RegWriteW=0, RDW=0, ResultW=0, LoadCnt=0 and StoreCnt=0 throughout.
2. ALU passthrough: RegWriteM=1, ResultSrcM=0, RDM=7, ALUResultM=30. One cycle later: RegWriteW=1, RDW=7, ResultW=30.
3. Store then load:
   - Cycle 1: MemWriteM=1, ALUResultM=0x10, WriteDataM=0xDEADBEEF.
   - Cycle 2: ResultSrcM=1, RegWriteM=1, RDM=3, ALUResultM=0x10.
   - Required: ResultW=0xDEADBEEF after cycle 2. The same result is required with ALUResultM=0x13 (low bits ignored) and with 0x110 at DEPTH=64 (wrap).
4. Simultaneous store and load:
   - Preload mem[4]=15.
   - Drive MemWriteM=1, ResultSrcM=1, ALUResultM=0x10, WriteDataM=20. Required: ResultW=15 next cycle.
   - Repeat the load alone. Required: ResultW=20.
5. Counters (MEM_PERF_CNT_EN defined):
   - Issue 3 loads, 2 stores and 1 load+store cycle. Required: LoadCnt=4, StoreCnt=3.
   - Assert rst. Required: both counters 0.
   - With the macro undefined, the same stimulus gives LoadCnt=StoreCnt=0.
6. Reset mid-stream:
   - Assert rst in the same cycle as a store of 0x55 to 0x20. Required: W outputs 0.
   - Deassert rst and load 0x20. Required: ResultW=0x55.
